// File: rtl/vsync_provider.sv
// Vertical timing stage: counts HSYNC falling edges into lines and frames, and decodes
// VSYNC, the visible-line Y coordinate and the vertical video-active flag.
module vsync_provider #(
  parameter int unsigned VerticalFrontPorch = 10,
  parameter int unsigned VSYNCPulse         = 2,
  parameter int unsigned VerticalBackPorch  = 33,
  parameter int unsigned VisibleLines       = 480
) (
  input  logic       Pixelclock,
  input  logic       reset,
  input  logic       enable,
  input  logic       HSYNC,
  output logic       VSYNC,
  output logic [9:0] Y,
  output logic       video_on_v,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned TOTAL =
      VerticalFrontPorch + VSYNCPulse + VerticalBackPorch + VisibleLines;

  localparam logic [9:0] LastLine  = 10'(TOTAL - 1);
  localparam logic [9:0] SyncStart = 10'(VerticalFrontPorch);
  localparam logic [9:0] SyncEnd   = 10'(VerticalFrontPorch + VSYNCPulse);
  localparam logic [9:0] VisStart  = 10'(VerticalFrontPorch + VSYNCPulse + VerticalBackPorch);

  if (TOTAL > 1024) begin : gen_total_check
    $error("vsync_provider: frame length exceeds the 10-bit line counter");
  end

  logic       hsync_d;
  logic [9:0] line_cnt;
  logic       adv;

  // hsync_d tracks HSYNC even while disabled, so re-enabling never sees a stale edge.
  assign adv = enable & hsync_d & ~HSYNC;

  always_ff @(posedge Pixelclock or posedge reset) begin
    if (reset) begin
      hsync_d     <= 1'b1;
      line_cnt    <= '0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      hsync_d     <= HSYNC;
      frame_start <= 1'b0;
      if (adv) begin
        if (line_cnt == LastLine) begin
          line_cnt    <= '0;
          frame_start <= 1'b1;
          frame_count <= frame_count + 8'd1;
        end else begin
          line_cnt <= line_cnt + 10'd1;
        end
      end
    end
  end

  assign VSYNC      = ~((line_cnt >= SyncStart) && (line_cnt < SyncEnd));
  assign video_on_v = (line_cnt >= VisStart);
  assign Y          = video_on_v ? (line_cnt - VisStart) : '0;

endmodule
